// File: rtl/cfg_data_axis_arbiter_if.sv
// AXI-stream bundle with 6-bit empty count and 11-bit queue id in tuser.
// The master drives payload and valid; the slave returns tready.
interface cfg_data_axis_arbiter_if #(
    parameter int DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [5:0]            tuser_mty;
    logic [10:0]           tuser_qid;

    modport master (
        output tdata, tvalid, tlast, tuser_mty, tuser_qid,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser_mty, tuser_qid,
        output tready
    );
endinterface

// File: rtl/cfg_data_axis_arbiter.sv
// Packet-atomic 2:1 AXI-stream arbiter (config vs data); 1 cycle to grant, 1-cycle registered output.
// Backpressure: the output register holds under m_tready=0 and the granted port sees tready=0.
module cfg_data_axis_arbiter #(
    parameter int DATA_WIDTH   = 512,
    parameter int CFG_PRIORITY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                           axis_aclk,
    input  logic                           axis_aresetn,
    cfg_data_axis_arbiter_if.slave         s0,
    cfg_data_axis_arbiter_if.slave         s1,
    cfg_data_axis_arbiter_if.master        m,
    output logic                           busy,
    output logic                           grant,
    output logic [31:0]                    pkt_cnt0,
    output logic [31:0]                    pkt_cnt1
);
    localparam int LW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                  state_q;
    logic                    grant_q;
    logic                    last_srv_q;
    logic [LW-1:0]           loss_q;
    logic                    m_vld_q;
    logic                    m_last_q;
    logic [DATA_WIDTH-1:0]   m_dat_q;
    logic [5:0]              m_mty_q;
    logic [10:0]             m_qid_q;
    logic [31:0]             cnt0_q;
    logic [31:0]             cnt1_q;

    logic                    grant_d;
    logic                    last_srv_d;
    logic [LW-1:0]           loss_d;

    logic                    out_free;
    logic                    accept;
    logic                    sel_vld;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic [5:0]              sel_mty;
    logic [10:0]             sel_qid;

    assign out_free = !m_vld_q || m.tready;

    assign sel_vld  = grant_q ? s1.tvalid    : s0.tvalid;
    assign sel_last = grant_q ? s1.tlast     : s0.tlast;
    assign sel_dat  = grant_q ? s1.tdata     : s0.tdata;
    assign sel_mty  = grant_q ? s1.tuser_mty : s0.tuser_mty;
    assign sel_qid  = grant_q ? s1.tuser_qid : s0.tuser_qid;

    assign accept    = (state_q == LOCK) && sel_vld && out_free;
    assign s0.tready = (state_q == LOCK) && !grant_q && out_free;
    assign s1.tready = (state_q == LOCK) &&  grant_q && out_free;

    // Only a contested arbitration touches the starvation counter.
    always_comb begin
        grant_d    = grant_q;
        loss_d     = loss_q;
        last_srv_d = last_srv_q;
        if (s0.tvalid && s1.tvalid) begin
            if (CFG_PRIORITY != 0) begin
                if (loss_q >= LW'(STARVE_LIMIT)) begin
                    grant_d = 1'b1;
                    loss_d  = '0;
                end else begin
                    grant_d = 1'b0;
                    loss_d  = loss_q + LW'(1);
                end
            end else begin
                grant_d = !last_srv_q;
            end
        end else begin
            grant_d = s1.tvalid;
        end
        last_srv_d = grant_d;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_srv_q <= 1'b1;
            loss_q     <= '0;
            m_vld_q    <= 1'b0;
            m_last_q   <= 1'b0;
            m_dat_q    <= '0;
            m_mty_q    <= '0;
            m_qid_q    <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s0.tvalid || s1.tvalid) begin
                        state_q    <= LOCK;
                        grant_q    <= grant_d;
                        loss_q     <= loss_d;
                        last_srv_q <= last_srv_d;
                    end
                end
                LOCK: begin
                    if (accept && sel_last) begin
                        state_q <= IDLE;
                        if (grant_q) cnt1_q <= cnt1_q + 32'd1;
                        else         cnt0_q <= cnt0_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Output stage refills in the same cycle it drains.
            if (out_free) begin
                m_vld_q <= accept;
                if (accept) begin
                    m_last_q <= sel_last;
                    m_dat_q  <= sel_dat;
                    m_mty_q  <= sel_mty;
                    m_qid_q  <= sel_qid;
                end
            end
        end
    end

    assign m.tvalid    = m_vld_q;
    assign m.tlast     = m_last_q;
    assign m.tdata     = m_dat_q;
    assign m.tuser_mty = m_mty_q;
    assign m.tuser_qid = m_qid_q;

    assign busy     = (state_q == LOCK);
    assign grant    = grant_q;
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
endmodule
